alu_seq_ctrl: RTL and testbench

Sequencer between the decode/issue stage and the registered ALU datapath. It accepts one operation at a time over a valid/ready handshake. It holds the ALU inputs stable for the ALU's internal register latency and drives the iterative-shift enable until the shifter reports completion. It returns the captured result, compare flag and carry on a valid/ready response channel.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_op_classify.sv | 32 +++
 rtl/alu_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode constants, state and op-class enums for the ALU sequencer
package alu_seq_pkg;

    // Major opcodes the sequencer understands
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 codes that select the iterative shifter
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_ARITH   = 2'd0,
        CLS_BRANCH  = 2'd1,
        CLS_SHIFT   = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

endpackage

// File: rtl/alu_op_classify.sv
// rtl/alu_op_classify.sv - combinational decode of funct3/opcode into an op class
//
// Ports:
//   i_funct3  in  3  funct3 field of the decoded instruction
//   i_opcode  in  7  opcode field of the decoded instruction
//   o_class   out 2  op_class_t encoding (arith, branch, shift, illegal)
module alu_op_classify
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_opcode,
    output logic [1:0] o_class
);

    logic w_is_alu_op;
    logic w_is_shift_f3;

    assign w_is_alu_op   = (i_opcode == OP_IMM) || (i_opcode == OP_REG);
    assign w_is_shift_f3 = (i_funct3 == F3_SLL) || (i_funct3 == F3_SRX);

    always_comb begin
        o_class = CLS_ILLEGAL;
        if (w_is_alu_op && w_is_shift_f3) begin
            o_class = CLS_SHIFT;
        end else if (w_is_alu_op) begin
            o_class = CLS_ARITH;
        end else if (i_opcode == OP_BRANCH) begin
            o_class = CLS_BRANCH;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - single-outstanding-op sequencer between issue and the registered ALU
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   flush                         abandon current op and any pending response
//   req_valid/req_ready           request handshake
//   req_decinst, req_rs1/rs2/inm  decoded op {funct7[5], x, funct3, opcode} and operands
//   alu_decinst, alu_op1/rs2/inm  held ALU inputs
//   alu_en                        iterative shifter enable
//   alu_result/cmp/carry/sl_ok    ALU outputs and shift-done
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/cmp/carry/err      captured response
//   busy                          controller not idle
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int SETTLE        = 3,
    parameter int SHIFT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_decinst,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_inm,
    output logic [11:0] alu_decinst,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_inm,
    output logic        alu_en,
    input  logic [31:0] alu_result,
    input  logic        alu_cmp,
    input  logic        alu_carry,
    input  logic        alu_sl_ok,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cmp,
    output logic        rsp_carry,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [7:0] TMO_LAST    = 8'(SHIFT_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  w_cls;
    logic [1:0]  r_cls;
    logic [7:0]  r_settle_cnt;
    logic [7:0]  r_tmo_cnt;

    logic [11:0] r_alu_decinst;
    logic [31:0] r_alu_op1;
    logic [31:0] r_alu_rs2;
    logic [31:0] r_alu_inm;
    logic [31:0] r_rsp_result;
    logic        r_rsp_cmp;
    logic        r_rsp_carry;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_settle_dec;
    logic        w_tmo_clr;
    logic        w_tmo_inc;
    logic        w_cap_alu;
    logic        w_cap_shift;
    logic        w_cap_err;

    alu_op_classify u_classify (
        .i_funct3 (req_decinst[9:7]),
        .i_opcode (req_decinst[6:0]),
        .o_class  (w_cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_settle_dec = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        w_cap_alu    = 1'b0;
        w_cap_shift  = 1'b0;
        w_cap_err    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    // Illegal ops never touch the ALU; the error response is loaded at accept.
                    w_state_nxt = (w_cls == CLS_ILLEGAL) ? ST_RESP : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == 8'd0) begin
                    if (r_cls == CLS_SHIFT) begin
                        w_tmo_clr   = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_cap_alu   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end else begin
                    w_settle_dec = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (alu_sl_ok) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_cap_err   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_cap_shift = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (flush) begin
            w_state_nxt  = ST_IDLE;
            w_accept     = 1'b0;
            w_settle_dec = 1'b0;
            w_tmo_clr    = 1'b0;
            w_tmo_inc    = 1'b0;
            w_cap_alu    = 1'b0;
            w_cap_shift  = 1'b0;
            w_cap_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cls         <= CLS_ILLEGAL;
            r_settle_cnt  <= 8'd0;
            r_tmo_cnt     <= 8'd0;
            r_alu_decinst <= 12'd0;
            r_alu_op1     <= 32'd0;
            r_alu_rs2     <= 32'd0;
            r_alu_inm     <= 32'd0;
            r_rsp_result  <= 32'd0;
            r_rsp_cmp     <= 1'b0;
            r_rsp_carry   <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cls         <= w_cls;
                r_settle_cnt  <= SETTLE_LOAD;
                r_alu_decinst <= req_decinst;
                r_alu_op1     <= req_rs1;
                r_alu_rs2     <= req_rs2;
                r_alu_inm     <= req_inm;
                r_rsp_result  <= 32'd0;
                r_rsp_cmp     <= 1'b0;
                r_rsp_carry   <= 1'b0;
                r_rsp_err     <= (w_cls == CLS_ILLEGAL);
            end

            if (w_settle_dec) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end

            if (w_tmo_clr) begin
                r_tmo_cnt <= 8'd0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end

            if (w_cap_alu) begin
                r_rsp_result <= alu_result;
                r_rsp_cmp    <= alu_cmp;
                r_rsp_carry  <= alu_carry;
                r_rsp_err    <= 1'b0;
            end

            // Shifts never produce a carry; the ALU carry output is stale here.
            if (w_cap_shift) begin
                r_rsp_result <= alu_result;
                r_rsp_cmp    <= alu_cmp;
                r_rsp_carry  <= 1'b0;
                r_rsp_err    <= 1'b0;
            end

            if (w_cap_err) begin
                r_rsp_result <= 32'd0;
                r_rsp_cmp    <= 1'b0;
                r_rsp_carry  <= 1'b0;
                r_rsp_err    <= 1'b1;
            end
        end
    end

    // req_ready drops while reset or flush is asserted so no accept is ever advertised.
    assign req_ready   = (r_state == ST_IDLE) && !reset && !flush;
    // Enable covers DRAIN so the ALU output register picks up the last shift step.
    assign alu_en      = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign rsp_valid   = (r_state == ST_RESP);
    assign busy        = (r_state != ST_IDLE);

    assign alu_decinst = r_alu_decinst;
    assign alu_op1     = r_alu_op1;
    assign alu_rs2     = r_alu_rs2;
    assign alu_inm     = r_alu_inm;
    assign rsp_result  = r_rsp_result;
    assign rsp_cmp     = r_rsp_cmp;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a behavioural registered ALU
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_decinst;
    logic [31:0] req_rs1, req_rs2, req_inm;
    logic [11:0] alu_decinst;
    logic [31:0] alu_op1, alu_rs2, alu_inm;
    logic        alu_en;
    logic [31:0] alu_result;
    logic        alu_cmp, alu_carry, alu_sl_ok;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cmp, rsp_carry, rsp_err;
    logic        busy;
    logic        block_ok;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.SETTLE(3), .SHIFT_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_decinst(req_decinst),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_inm(req_inm),
        .alu_decinst(alu_decinst), .alu_op1(alu_op1), .alu_rs2(alu_rs2), .alu_inm(alu_inm),
        .alu_en(alu_en), .alu_result(alu_result), .alu_cmp(alu_cmp), .alu_carry(alu_carry),
        .alu_sl_ok(alu_sl_ok), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cmp(rsp_cmp), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Behavioural ALU: registered add/compare, iterative shifter stepping by 4 then by 1.
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_is_shift;
    logic [4:0]  m_amt;
    logic [31:0] m_sh  = 32'd0;
    logic [5:0]  m_rem = 6'd0;
    logic [31:0] m_res = 32'd0;
    logic        m_carry_q = 1'b0;
    logic        m_cmp_q   = 1'b0;

    assign m_opc      = alu_decinst[6:0];
    assign m_f3       = alu_decinst[9:7];
    assign m_is_shift = (m_opc == 7'b0010011 || m_opc == 7'b0110011) && (m_f3 == 3'b001 || m_f3 == 3'b101);
    assign m_amt      = (m_opc == 7'b0110011) ? alu_rs2[4:0] : alu_inm[4:0];

    function automatic logic [31:0] sh_step(logic [31:0] x, int k, logic [2:0] f3, logic ar);
        if (f3 == 3'b001) return x << k;
        else if (ar)      return $signed(x) >>> k;
        else              return x >> k;
    endfunction

    always @(posedge clk) begin
        if (!alu_en) begin
            m_sh  <= alu_op1;
            m_rem <= {1'b0, m_amt};
        end else if (m_rem >= 6'd4) begin
            m_sh  <= sh_step(m_sh, 4, m_f3, alu_decinst[11]);
            m_rem <= m_rem - 6'd4;
        end else if (m_rem != 6'd0) begin
            m_sh  <= sh_step(m_sh, 1, m_f3, alu_decinst[11]);
            m_rem <= m_rem - 6'd1;
        end
        {m_carry_q, m_res} <= {1'b0, alu_op1} + {1'b0, (m_opc == 7'b0110011) ? alu_rs2 : alu_inm};
        m_cmp_q <= (m_opc == 7'b1100011) && (alu_op1 == alu_inm);
    end

    assign alu_result = m_is_shift ? m_sh : ((m_opc == 7'b1100011) ? 32'd0 : m_res);
    assign alu_carry  = (m_is_shift || m_opc == 7'b1100011) ? 1'b0 : m_carry_q;
    assign alu_cmp    = m_cmp_q;
    assign alu_sl_ok  = alu_en && (m_rem == 6'd0) && !block_ok;

    typedef struct {
        logic [11:0] dec;
        logic [31:0] rs1, rs2, inm;
        logic        blk;
        logic [31:0] res;
        logic        cmp, carry, err;
        int          lat, en;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic logic [11:0] dec(logic f7b, logic [2:0] f3, logic [6:0] opc);
        return {f7b, 1'b0, f3, opc};
    endfunction

    function automatic vec_t mk(logic [11:0] d, logic [31:0] a, logic [31:0] b, logic [31:0] im,
                                logic blk, logic [31:0] res, logic cmp, logic carry, logic err,
                                int lat, int en);
        vec_t v;
        v.dec = d; v.rs1 = a; v.rs2 = b; v.inm = im; v.blk = blk;
        v.res = res; v.cmp = cmp; v.carry = carry; v.err = err; v.lat = lat; v.en = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drives one request, pushes its expectation, and checks the response against the popped entry.
    task automatic do_op(input vec_t v, input string tag);
        vec_t e;
        int   lat, en, n;
        @(negedge clk);
        req_decinst = v.dec; req_rs1 = v.rs1; req_rs2 = v.rs2; req_inm = v.inm;
        block_ok = v.blk; req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, " req_ready"}, req_ready, 1);
        @(posedge clk);
        exp_q.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; en = 0;
        while (!rsp_valid && lat < 200) begin
            if (alu_en) en++;
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " alu_en cycles"}, en, e.en);
        chk({tag, " result"}, rsp_result, e.res);
        chk({tag, " cmp"}, rsp_cmp, e.cmp);
        chk({tag, " carry"}, rsp_carry, e.carry);
        chk({tag, " err"}, rsp_err, e.err);
        @(negedge clk);
        chk({tag, " idle after rsp"}, {busy, rsp_valid}, 2'b00);
        block_ok = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; block_ok = 1'b0;
        req_decinst = 12'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_inm = 32'd0;

        vecs.push_back(mk(dec(0, 3'b000, 7'b0110011), 32'd5, 32'd7, 32'd0, 0, 32'd12, 0, 0, 0, 3, 0));
        vecs.push_back(mk(dec(0, 3'b000, 7'b0110011), 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 32'd0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(dec(0, 3'b000, 7'b0010011), 32'd100, 32'd0, 32'd23, 0, 32'd123, 0, 0, 0, 3, 0));
        vecs.push_back(mk(dec(0, 3'b001, 7'b0110011), 32'd1, 32'd6, 32'd0, 0, 32'h40, 0, 0, 0, 8, 5));
        vecs.push_back(mk(dec(0, 3'b101, 7'b0010011), 32'h8000_0000, 32'd0, 32'd31, 0, 32'd1, 0, 0, 0, 15, 12));
        vecs.push_back(mk(dec(1, 3'b101, 7'b0010011), 32'h8000_0000, 32'd0, 32'd4, 0, 32'hF800_0000, 0, 0, 0, 6, 3));
        vecs.push_back(mk(dec(0, 3'b001, 7'b0110011), 32'h1234, 32'd0, 32'd0, 0, 32'h1234, 0, 0, 0, 5, 2));
        vecs.push_back(mk(dec(0, 3'b000, 7'b1100011), 32'd9, 32'd0, 32'd9, 0, 32'd0, 1, 0, 0, 3, 0));
        vecs.push_back(mk(dec(0, 3'b000, 7'b1100011), 32'd9, 32'd0, 32'd8, 0, 32'd0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(12'h000, 32'd5, 32'd7, 32'd0, 0, 32'd0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(12'h037, 32'd5, 32'd7, 32'd3, 0, 32'd0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(dec(0, 3'b001, 7'b0110011), 32'd1, 32'd6, 32'd0, 1, 32'd0, 0, 0, 1, 19, 16));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid/alu_en/busy", {rsp_valid, alu_en, busy}, 3'b000);
        chk("reset alu_op1", alu_op1, 0);
        chk("reset alu_decinst", alu_decinst, 0);
        chk("reset rsp fields", {rsp_result[0], rsp_cmp, rsp_carry, rsp_err}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", req_ready, 1);

        foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

        // beq with the consumer stalled: response must hold and no new request accepted
        @(negedge clk);
        req_decinst = dec(0, 3'b000, 7'b1100011); req_rs1 = 32'd42; req_inm = 32'd42; req_rs2 = 32'd0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("stall rsp_valid seen", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall c%0d hold", k), {rsp_valid, rsp_cmp, req_ready, rsp_err}, 4'b1100);
            chk($sformatf("stall c%0d result", k), rsp_result, 0);
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall released busy", busy, 0);

        // flush while shifting
        req_decinst = dec(0, 3'b101, 7'b0010011); req_rs1 = 32'hFFFF_0000; req_inm = 32'd31;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!alu_en && n < 50) begin @(negedge clk); n++; end
        chk("flush reached SHIFT", alu_en, 1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush alu_en/rsp_valid/busy", {alu_en, rsp_valid, busy}, 3'b000);
        req_decinst = dec(0, 3'b000, 7'b0110011); req_rs1 = 32'd8; req_rs2 = 32'd8;
        req_valid = 1'b1;
        @(negedge clk);
        chk("flush beats req_valid", busy, 0);
        req_valid = 1'b0; flush = 1'b0;
        do_op(mk(dec(0, 3'b000, 7'b0110011), 32'd1, 32'd1, 32'd0, 0, 32'd2, 0, 0, 0, 3, 0), "after flush");

        // reset while a response is pending
        @(negedge clk);
        req_decinst = dec(0, 3'b000, 7'b0110011); req_rs1 = 32'd3; req_rs2 = 32'd4;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("pre-reset rsp_result", rsp_result, 7);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset rsp_valid/alu_en/busy", {rsp_valid, alu_en, busy}, 3'b000);
        chk("mid reset rsp_result cleared", rsp_result, 0);
        reset = 1'b0;
        do_op(mk(dec(0, 3'b000, 7'b0110011), 32'd1, 32'd1, 32'd0, 0, 32'd2, 0, 0, 0, 3, 0), "after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
